multi_channel_timer: RTL and testbench

- Bank of NUM_CH independent fraction-of-a-second timers for game events: attack cooldowns, hit-stun, round clock ticks and animation frames.
- Each channel has its own start, cancel, pause, fraction select and one-shot/periodic mode.
- Each channel produces done and halfway pulses plus a running flag.
- Sits between the game FSM and the sprite/animation logic; replaces per-event single-timer instances.

---
 rtl/timer_defs_pkg.sv | 17 +
 rtl/timer_channel.sv | 107 ++++++++++
 rtl/multi_channel_timer.sv | 60 ++++++
 tb/tb_multi_channel_timer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_defs_pkg.sv
// Shared definitions for the multi-channel game timer: mode encodings,
// default clock rate and the period lookup used at elaboration time.
package timer_defs;

   localparam int   DEFAULT_CLOCK_FREQ = 100_000_000;
   localparam logic MODE_ONESHOT       = 1'b0;
   localparam logic MODE_PERIODIC      = 1'b1;

   // Fraction 0 means a full second; otherwise a truncated 1/fraction of a second.
   function automatic int period_of(input int fraction, input int clock_freq);
      case (fraction)
         0:       return clock_freq;
         default: return clock_freq / fraction;
      endcase
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, latched period/mode and the done/halfway pulse
// generation. Also exposes the next-cycle done value so the top can register any_done.
module timer_channel
   import timer_defs::*;
#(
   parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
   parameter int CNT_W      = 32,
   parameter int FRAC_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_cancel,
   input  logic              i_pause,
   input  logic              i_periodic,
   input  logic [FRAC_W-1:0] i_fraction,
   output logic              o_done,
   output logic              o_halfway,
   output logic              o_running,
   output logic              o_done_next
);

   localparam int NUM_FRAC = 2 ** FRAC_W;

   // Constant table of periods, one entry per fraction code; selected by a plain mux.
   logic [CNT_W-1:0] w_period_lut [NUM_FRAC];

   generate
      for (genvar gi = 0; gi < NUM_FRAC; gi++) begin : g_lut
         assign w_period_lut[gi] = CNT_W'(period_of(gi, CLOCK_FREQ));
      end
   endgenerate

   logic [CNT_W-1:0] r_count, r_count_next;
   logic [CNT_W-1:0] r_period, r_period_next;
   logic             r_mode, r_mode_next;
   logic             r_running, r_running_next;
   logic             r_done, r_done_next;
   logic             r_half, r_half_next;

   logic [CNT_W-1:0] w_period_sel;
   logic [CNT_W-1:0] w_last;
   logic [CNT_W-1:0] w_half;
   logic [CNT_W-1:0] w_half_m1;

   assign w_period_sel = w_period_lut[i_fraction];
   assign w_last       = r_period - CNT_W'(1);
   assign w_half       = r_period >> 1;
   assign w_half_m1    = w_half - CNT_W'(1);

   always_comb begin
      r_count_next   = r_count;
      r_period_next  = r_period;
      r_mode_next    = r_mode;
      r_running_next = r_running;
      r_done_next    = 1'b0;
      r_half_next    = 1'b0;

      if (i_cancel) begin
         r_running_next = 1'b0;
         r_count_next   = '0;
      end else if (i_start) begin
         r_running_next = 1'b1;
         r_count_next   = '0;
         r_period_next  = w_period_sel;
         r_mode_next    = i_periodic;
      end else if (r_running && !i_pause) begin
         // A period of 1 has no half point, so the halfway compare is gated off.
         if ((w_half != '0) && (r_count == w_half_m1)) begin
            r_half_next = 1'b1;
         end
         if (r_count == w_last) begin
            r_done_next  = 1'b1;
            r_count_next = '0;
            if (r_mode == MODE_ONESHOT) begin
               r_running_next = 1'b0;
            end
         end else begin
            r_count_next = r_count + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_period  <= '0;
         r_mode    <= MODE_ONESHOT;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_half    <= 1'b0;
      end else begin
         r_count   <= r_count_next;
         r_period  <= r_period_next;
         r_mode    <= r_mode_next;
         r_running <= r_running_next;
         r_done    <= r_done_next;
         r_half    <= r_half_next;
      end
   end

   assign o_done      = r_done;
   assign o_halfway   = r_half;
   assign o_running   = r_running;
   assign o_done_next = r_done_next;

endmodule

// File: rtl/multi_channel_timer.sv
// Bank of independent fraction-of-a-second timers; one timer_channel per channel
// plus a registered OR of all done pulses.
module multi_channel_timer
   import timer_defs::*;
#(
   parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int FRAC_W     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        start,
   input  logic [NUM_CH-1:0]        cancel,
   input  logic [NUM_CH-1:0]        pause,
   input  logic [NUM_CH-1:0]        periodic,
   input  logic [NUM_CH*FRAC_W-1:0] fraction,
   output logic [NUM_CH-1:0]        done,
   output logic [NUM_CH-1:0]        halfway,
   output logic [NUM_CH-1:0]        running,
   output logic                     any_done
);

   logic [NUM_CH-1:0] w_done_next;
   logic              r_any_done;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         timer_channel #(
            .CLOCK_FREQ (CLOCK_FREQ),
            .CNT_W      (CNT_W),
            .FRAC_W     (FRAC_W)
         ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_start     (start[gi]),
            .i_cancel    (cancel[gi]),
            .i_pause     (pause[gi]),
            .i_periodic  (periodic[gi]),
            .i_fraction  (fraction[gi*FRAC_W +: FRAC_W]),
            .o_done      (done[gi]),
            .o_halfway   (halfway[gi]),
            .o_running   (running[gi]),
            .o_done_next (w_done_next[gi])
         );
      end
   endgenerate

   // Registered from the channels' next-done values so it rises with done itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_any_done <= 1'b0;
      end else begin
         r_any_done <= |w_done_next;
      end
   end

   assign any_done = r_any_done;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed scenarios plus randomized traffic, checked against an event-time
// reference model (scheduled done/halfway edges shifted by pauses).
module tb_multi_channel_timer;

   localparam int CF  = 16;
   localparam int NCH = 4;
   localparam int FW  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    start, cancel, pause, periodic;
   logic [NCH*FW-1:0] fraction;
   logic [NCH-1:0]    done, halfway, running;
   logic              any_done;

   multi_channel_timer #(
      .CLOCK_FREQ (CF),
      .NUM_CH     (NCH),
      .CNT_W      (32),
      .FRAC_W     (FW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .cancel   (cancel),
      .pause    (pause),
      .periodic (periodic),
      .fraction (fraction),
      .done     (done),
      .halfway  (halfway),
      .running  (running),
      .any_done (any_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int t     = 0;

   // Reference state: armed flag, mode, period, and absolute edge numbers
   // at which the next done / halfway pulse is due.
   int m_armed [NCH];
   int m_mode  [NCH];
   int m_per   [NCH];
   int m_dd    [NCH];
   int m_dh    [NCH];

   logic [NCH-1:0] exp_done, exp_half, exp_run;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   function automatic int ref_period(input int f);
      return (f == 0) ? CF : CF / f;
   endfunction

   task automatic model_edge();
      exp_done = '0;
      exp_half = '0;
      for (int c = 0; c < NCH; c++) begin
         int f;
         f = int'(fraction[c*FW +: FW]);
         if (reset) begin
            m_armed[c] = 0;
            m_mode[c]  = 0;
            m_per[c]   = 0;
         end else if (cancel[c]) begin
            m_armed[c] = 0;
         end else if (start[c]) begin
            m_armed[c] = 1;
            m_per[c]   = ref_period(f);
            m_mode[c]  = int'(periodic[c]);
            m_dd[c]    = t + m_per[c];
            m_dh[c]    = (m_per[c] / 2 >= 1) ? t + m_per[c] / 2 : -1;
         end else if (m_armed[c] != 0 && pause[c]) begin
            m_dd[c]++;
            if (m_dh[c] >= 0) m_dh[c]++;
         end else if (m_armed[c] != 0) begin
            if (t == m_dh[c]) exp_half[c] = 1'b1;
            if (t == m_dd[c]) begin
               exp_done[c] = 1'b1;
               if (m_mode[c] != 0) begin
                  m_dd[c] = t + m_per[c];
                  m_dh[c] = (m_per[c] / 2 >= 1) ? t + m_per[c] / 2 : -1;
               end else begin
                  m_armed[c] = 0;
               end
            end
         end
         exp_run[c] = (m_armed[c] != 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      t++;
      model_edge();
      #1;
      check("done",     32'(done),     32'(exp_done));
      check("halfway",  32'(halfway),  32'(exp_half));
      check("running",  32'(running),  32'(exp_run));
      check("any_done", 32'(any_done), 32'(|exp_done));
   endtask

   task automatic idle();
      reset  = 1'b0;
      start  = '0;
      cancel = '0;
      pause  = '0;
   endtask

   task automatic set_frac(input int c, input int f);
      fraction[c*FW +: FW] = FW'(f);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_armed[c] = 0; m_mode[c] = 0; m_per[c] = 0; m_dd[c] = -1; m_dh[c] = -1;
      end
      idle();
      periodic = '0;
      fraction = '0;

      // Reset state
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      $display("scenario 0 reset edge=%0d", t);

      // 1: one-shot, P=4
      set_frac(0, 4); periodic = 4'b0000; start = 4'b0001;
      step(); start = '0;
      run(6);
      $display("scenario 1 one-shot P=4 edge=%0d", t);

      // 2: periodic P=2, cancelled at edge 5
      set_frac(1, 8); periodic = 4'b0010; start = 4'b0010;
      step(); start = '0;
      run(4);
      cancel = 4'b0010; step(); cancel = '0;
      run(5);
      $display("scenario 2 periodic + cancel edge=%0d", t);

      // 3: P=8 with pause over edges 3..5 and a fraction change mid-count
      set_frac(2, 2); periodic = 4'b0000; start = 4'b0100;
      step(); start = '0;
      step();
      set_frac(2, 1); step();
      pause = 4'b0100; run(3); pause = '0;
      run(10);
      $display("scenario 3 pause edge=%0d", t);

      // 4: retrigger mid-count, then retrigger on the terminal edge
      set_frac(3, 4); start = 4'b1000;
      step(); start = '0;
      run(2);
      start = 4'b1000; step(); start = '0;
      run(5);
      start = 4'b1000; step(); start = '0;
      run(3);
      start = 4'b1000; step(); start = '0;
      run(6);
      $display("scenario 4 retrigger edge=%0d", t);

      // 5: all channels together, fractions 0,1,2,4
      set_frac(0, 0); set_frac(1, 1); set_frac(2, 2); set_frac(3, 4);
      periodic = '0; start = 4'b1111;
      step(); start = '0;
      run(18);
      $display("scenario 5 simultaneous edge=%0d", t);

      // 6: reset mid-count
      periodic = 4'b1010; start = 4'b1111;
      step(); start = '0;
      run(3);
      reset = 1'b1; step(); reset = 1'b0;
      run(20);
      $display("scenario 6 reset mid-count edge=%0d", t);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 399) == 0);
         fraction = NCH*FW'($urandom);
         periodic = NCH'($urandom);
         for (int c = 0; c < NCH; c++) begin
            start[c]  = ($urandom_range(0, 11) == 0);
            cancel[c] = ($urandom_range(0, 39) == 0);
            pause[c]  = ($urandom_range(0, 3) == 0);
         end
         step();
      end
      idle();
      $display("scenario 7 random edge=%0d", t);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
